// File: rtl/seq_pkg.sv
// Shared definitions for the 10110 pattern transmitter and its companion detector.
package seq_pkg;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned REP_W   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned IDX_W   = $clog2(WIDTH);
    localparam int unsigned SEQ_LEN = 5;

    localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 5'b10110;
    localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_e;

    typedef enum logic [2:0] {
        S0,
        S1,
        S10,
        S101,
        S1011,
        S10110
    } trk_state_e;

    // Zero and anything beyond the shift register mean "use the full width".
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == LEN_W'(0) || len > LEN_W'(WIDTH)) begin
            return LEN_W'(WIDTH);
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Load handshake and serial stream of the pattern transmitter.
interface seq_pattern_tx_if;
    import seq_pkg::*;

    logic              load_valid;
    logic              load_ready;
    logic [WIDTH-1:0]  pattern;
    logic [LEN_W-1:0]  length;
    logic [REP_W-1:0]  repeats;
    logic              data;
    logic              data_valid;
    logic              last;
    logic [CNT_W-1:0]  match_cnt;

    modport master (
        output load_valid, pattern, length, repeats,
        input  load_ready, data, data_valid, last, match_cnt
    );

    modport slave (
        input  load_valid, pattern, length, repeats,
        output load_ready, data, data_valid, last, match_cnt
    );

endinterface

// File: rtl/seq_10110_tracker.sv
// Overlapping 10110 recognizer; hit flags the bit that completes a match.
module seq_10110_tracker
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_valid,
    input  logic stream_bit,
    output logic hit
);

    trk_state_e state_q;
    trk_state_e state_d;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Mismatch fallbacks keep the longest suffix that is still a prefix of 10110.
    always_comb begin
        state_d = state_q;
        if (bit_valid) begin
            case (state_q)
                S0:      state_d = (stream_bit == SEQ_PATTERN[SEQ_LEN-1]) ? S1     : S0;
                S1:      state_d = (stream_bit == SEQ_PATTERN[SEQ_LEN-2]) ? S10    : S1;
                S10:     state_d = (stream_bit == SEQ_PATTERN[SEQ_LEN-3]) ? S101   : S0;
                S101:    state_d = (stream_bit == SEQ_PATTERN[SEQ_LEN-4]) ? S1011  : S10;
                S1011:   state_d = (stream_bit == SEQ_PATTERN[SEQ_LEN-5]) ? S10110 : S1;
                S10110:  state_d = (stream_bit == SEQ_PATTERN[SEQ_LEN-3]) ? S101   : S0;
                default: state_d = S0;
            endcase
        end
    end

    // Decoded from the next state so the count updates on the edge that consumes the bit.
    assign hit = bit_valid && (state_d == S10110);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: MSB-first shift with repeats and a golden 10110 match count.
module seq_pattern_tx
    import seq_pkg::*;
(
    input logic             clk,
    input logic             rst,
    seq_pattern_tx_if.slave bus
);

    tx_state_e          state_q, state_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic               data_q, data_d;
    logic               dvalid_q, dvalid_d;
    logic               last_q, last_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               hit;
    logic [LEN_W-1:0]   len_in;
    logic [LEN_W-1:0]   first_idx;
    logic [LEN_W-1:0]   reload_idx;
    logic [LEN_W-1:0]   next_idx;

    seq_10110_tracker u_tracker (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .bit_valid  (dvalid_q),
        .stream_bit (data_q),
        .hit        (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            rep_q    <= '0;
            pat_q    <= '0;
            data_q   <= 1'b0;
            dvalid_q <= 1'b0;
            last_q   <= 1'b0;
            ready_q  <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            rep_q    <= rep_d;
            pat_q    <= pat_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            last_q   <= last_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and next-output logic; outputs describe the bit shown after the edge.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        rep_d      = rep_q;
        pat_d      = pat_q;
        data_d     = 1'b0;
        dvalid_d   = 1'b0;
        last_d     = 1'b0;
        ready_d    = ready_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        len_in     = clamp_len(bus.length);
        first_idx  = len_in - LEN_W'(1);
        reload_idx = len_q - LEN_W'(1);
        next_idx   = idx_q - LEN_W'(1);

        if (hit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.load_valid && ready_q) begin
                    accept   = 1'b1;
                    state_d  = SHIFT;
                    pat_d    = bus.pattern;
                    len_d    = len_in;
                    rep_d    = bus.repeats;
                    idx_d    = first_idx;
                    data_d   = bus.pattern[first_idx[IDX_W-1:0]];
                    dvalid_d = 1'b1;
                    last_d   = (len_in == LEN_W'(1)) && (bus.repeats == REP_W'(0));
                    ready_d  = 1'b0;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                dvalid_d = 1'b1;
                if (idx_q == LEN_W'(0)) begin
                    if (rep_q != REP_W'(0)) begin
                        // Wrap to the MSB with no gap so the stream stays contiguous.
                        rep_d  = rep_q - REP_W'(1);
                        idx_d  = reload_idx;
                        data_d = pat_q[reload_idx[IDX_W-1:0]];
                        last_d = (len_q == LEN_W'(1)) && (rep_q == REP_W'(1));
                    end else begin
                        state_d  = IDLE;
                        dvalid_d = 1'b0;
                        ready_d  = 1'b1;
                    end
                end else begin
                    idx_d  = next_idx;
                    data_d = pat_q[next_idx[IDX_W-1:0]];
                    last_d = (idx_q == LEN_W'(1)) && (rep_q == REP_W'(0));
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign bus.load_ready = ready_q;
    assign bus.data       = data_q;
    assign bus.data_valid = dvalid_q;
    assign bus.last       = last_q;
    assign bus.match_cnt  = cnt_q;

endmodule
